// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used across the datapath.
package cpu_types_pkg;
   typedef logic [4:0] regbits_t;
endpackage

// File: rtl/forward_pkg.sv
// Types and constants for the forwarding scoreboard and its match slices.
package forward_pkg;
   import cpu_types_pkg::regbits_t;

   typedef struct packed {
      logic     valid;
      logic     wen;
      regbits_t wsel;
      logic     is_load;
   } fwd_entry_t;

   localparam int FWD_REGFILE = 0;
endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against the in-flight shadow entries.
import cpu_types_pkg::*;
import forward_pkg::*;

module fwd_match #(
   parameter int NSTAGES    = 3,
   parameter int LOAD_READY = 2,
   parameter int SELW       = $clog2(NSTAGES + 1)
) (
   input  fwd_entry_t [NSTAGES-1:0] entries,
   input  logic                     src_valid,
   input  regbits_t                 src_reg,
   output logic [SELW-1:0]          sel,
   output logic                     load_hazard
);

   // Scan oldest to youngest so the youngest producer overwrites the result.
   always_comb begin
      sel         = SELW'(FWD_REGFILE);
      load_hazard = 1'b0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (src_valid && (src_reg != '0) && entries[k].valid &&
             entries[k].wen && (entries[k].wsel == src_reg)) begin
            sel         = SELW'(k + 1);
            load_hazard = entries[k].is_load && (k < LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Shadow of in-flight destinations: selects forwarding sources per operand,
// raises load-use stalls and counts stalled advancing cycles.
import cpu_types_pkg::*;
import forward_pkg::*;

module forwarding_scoreboard #(
   parameter int NSTAGES    = 3,
   parameter int NSRC       = 2,
   parameter int LOAD_READY = 2,
   parameter int CNTW       = 16,
   localparam int SELW      = $clog2(NSTAGES + 1)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   advance,
   input  logic                   issue_valid,
   input  logic                   issue_wen,
   input  regbits_t               issue_wsel,
   input  logic                   issue_is_load,
   input  logic                   flush,
   input  logic [NSRC-1:0]        src_valid,
   input  logic [NSRC*5-1:0]      src_regs,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic                   stall,
   output logic [CNTW-1:0]        stall_count
);

   fwd_entry_t [NSTAGES-1:0] entry_reg;
   fwd_entry_t               entry_next;
   logic [CNTW-1:0]          stall_count_reg;
   logic [NSRC-1:0]          hazard;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         fwd_match #(
            .NSTAGES    (NSTAGES),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
         ) u_match (
            .entries     (entry_reg),
            .src_valid   (src_valid[gi]),
            .src_reg     (src_regs[gi*5 +: 5]),
            .sel         (fwd_sel[gi*SELW +: SELW]),
            .load_hazard (hazard[gi])
         );
      end
   endgenerate

   assign stall = |hazard;

   // A stalled or flushed decode slot enters the pipe as a bubble.
   always_comb begin
      entry_next.valid   = issue_valid && !stall && !flush;
      entry_next.wen     = issue_wen;
      entry_next.wsel    = issue_wsel;
      entry_next.is_load = issue_is_load;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         entry_reg       <= '0;
         stall_count_reg <= '0;
      end else if (advance) begin
         for (int j = NSTAGES - 1; j > 0; j--) begin
            entry_reg[j] <= entry_reg[j-1];
         end
         entry_reg[0] <= entry_next;
         if (stall && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + CNTW'(1);
         end
      end
   end

   assign stall_count = stall_count_reg;

endmodule
